pio_edge_capture_in: RTL and testbench

PIO_EDGE_CAPTURE_IN -- requirements
Module: pio_edge_capture_in

---
 rtl/pio_edge_capture_in.sv | 100 ++++++++++
 tb/tb_pio_edge_capture_in.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pio_edge_capture_in.sv
// Avalon-MM parallel input port with per-bit edge capture and interrupt.
// Define PIO_EDGE_SYNC_EN to put a two-flop synchroniser in front of in_port.
module pio_edge_capture_in #(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = 0,
    parameter int IRQ_TYPE  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] clr_bits;
    logic [31:0]      rd_next;
    logic             wr_en;
    logic             unused_wd;

`ifdef PIO_EDGE_SYNC_EN
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    assign data_in = sync2;
`else
    assign data_in = in_port;
`endif

    assign wr_en     = chipselect && !write_n;
    assign unused_wd = ^writedata;

    always_comb begin
        edge_evt = '0;
        case (EDGE_TYPE)
            0:       edge_evt = data_in & ~prev;
            1:       edge_evt = ~data_in & prev;
            default: edge_evt = data_in ^ prev;
        endcase
    end

    always_comb begin
        clr_bits = '0;
        if (wr_en && address == 2'd3)
            clr_bits = writedata[WIDTH-1:0];
    end

    always_comb begin
        rd_next = '0;
        case (address)
            2'd0:    rd_next = 32'(data_in);
            2'd2:    rd_next = 32'(irqmask);
            2'd3:    rd_next = 32'(edgecapture);
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev        <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            readdata    <= '0;
        end else begin
            prev     <= data_in;
            readdata <= rd_next;
            // OR-ing the new events last lets a same-cycle edge beat a clear
            edgecapture <= (edgecapture & ~clr_bits) | edge_evt;
            if (wr_en && address == 2'd2)
                irqmask <= writedata[WIDTH-1:0];
        end
    end

    generate
        if (IRQ_TYPE == 1) begin : g_irq_edge
            assign irq = |(edgecapture & irqmask);
        end else begin : g_irq_level
            assign irq = |(data_in & irqmask);
        end
    endgenerate

endmodule

// File: tb/tb_pio_edge_capture_in.sv
// Directed scoreboard bench for pio_edge_capture_in (rising and falling
// instances); honours PIO_EDGE_SYNC_EN for the latency test.
module tb_pio_edge_capture_in;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    logic [1:0]  address1;
    logic        chipselect1;
    logic        write_n1;
    logic [31:0] writedata1;
    logic [7:0]  in_port1;
    logic [31:0] readdata1;
    logic        irq1;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pio_edge_capture_in #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_TYPE(1)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    pio_edge_capture_in #(.WIDTH(8), .EDGE_TYPE(1), .IRQ_TYPE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address1),
        .chipselect(chipselect1), .write_n(write_n1),
        .writedata(writedata1), .in_port(in_port1),
        .readdata(readdata1), .irq(irq1)
    );

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
    endtask

    task automatic bus_idle;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        reset_n     = 1'b0;
        address     = 2'd0;
        chipselect  = 1'b0;
        write_n     = 1'b1;
        writedata   = '0;
        in_port     = 8'h00;
        address1    = 2'd3;
        chipselect1 = 1'b0;
        write_n1    = 1'b1;
        writedata1  = '0;
        in_port1    = 8'hFF;

        #2;
        push("rst_readdata", 32'h0);
        check(readdata);
        push("rst_irq", 32'h0);
        check(32'(irq));
        #20 reset_n = 1'b1;
        tick;

`ifdef PIO_EDGE_SYNC_EN
        in_port = 8'h3C;
        address = 2'd0;
        push("sync_n", 32'h0);
        tick;
        check(readdata);
        push("sync_n1", 32'h0);
        tick;
        check(readdata);
        push("sync_n2", 32'h3C);
        tick;
        check(readdata);
        #3 reset_n = 1'b0;
        #1;
        push("sync_rst_rd", 32'h0);
        check(readdata);
        push("sync_rst_irq", 32'h0);
        check(32'(irq));
`else
        in_port  = 8'hA5;
        address  = 2'd0;
        in_port1 = 8'hF0;
        push("rd_data", 32'hA5);
        tick;
        check(readdata);

        address = 2'd1;
        push("rd_rsvd", 32'h0);
        tick;
        check(readdata);
        push("fall_cap", 32'h0F);
        check(readdata1);
        in_port1 = 8'hFF;

        bus_write(2'd3, 32'hFF);
        push("rd_ec_pre", 32'hA5);
        tick;
        check(readdata);
        bus_idle;

        in_port = 8'h00;
        bus_write(2'd2, 32'hFFFF_FF01);
        tick;
        bus_idle;
        tick;
        push("fall_no_rise", 32'h0F);
        check(readdata1);
        push("irq_idle", 32'h0);
        check(32'(irq));

        in_port = 8'h81;
        address = 2'd3;
        tick;
        tick;
        push("ec_81", 32'h81);
        check(readdata);
        push("irq_set", 32'h1);
        check(32'(irq));

        address = 2'd2;
        push("rd_mask", 32'h01);
        tick;
        check(readdata);

        bus_write(2'd3, 32'h01);
        tick;
        bus_idle;
        push("irq_clr", 32'h0);
        check(32'(irq));
        address = 2'd3;
        push("ec_80", 32'h80);
        tick;
        check(readdata);

        in_port = 8'h85;
        bus_write(2'd3, 32'h04);
        tick;
        bus_idle;
        address = 2'd3;
        push("set_wins", 32'h84);
        tick;
        check(readdata);

        in_port = 8'h00;
        bus_write(2'd2, 32'hFF);
        tick;
        bus_idle;
        in_port = 8'hFF;
        tick;
        address = 2'd3;
        push("ec_ff", 32'hFF);
        tick;
        check(readdata);
        push("irq_ff", 32'h1);
        check(32'(irq));

        #3 reset_n = 1'b0;
        #1;
        push("arst_rd", 32'h0);
        check(readdata);
        push("arst_irq", 32'h0);
        check(32'(irq));
        push("arst_ec", 32'h0);
        check(32'(u_rise.edgecapture));
        push("arst_mask", 32'h0);
        check(32'(u_rise.irqmask));
        tick;
        #3 reset_n = 1'b1;
        tick;
        push("rel_edge", 32'hFF);
        tick;
        check(readdata);
        push("rel_irq", 32'h0);
        check(32'(irq));
`endif

        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_left observed=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
